// File: rtl/inst_fetch_cache.sv
// inst_fetch_cache
// Direct-mapped, one-word-per-line instruction buffer between the core fetch
// port and a slow handshaked instruction memory. A hit answers combinationally,
// so the core sees ROM-like timing. A miss raises stall_from_if while the line
// is refilled through a valid/ready request and a valid-only response.
//
// Ports:
//   clock, reset     - system clock; synchronous active-high reset
//   rom_chip_enable  - core fetch enable
//   rom_addr         - word-aligned fetch address
//   flush            - invalidate every entry at the next edge
//   rom_data         - fetched instruction (0 / NOP when not a hit)
//   stall_from_if    - fetch-miss stall request to the pipeline control
//   mem_req_valid    - memory read request valid
//   mem_req_addr     - memory read request address
//   mem_req_ready    - memory accepts the request
//   mem_resp_valid   - memory read data valid
//   mem_resp_data    - memory read data
module inst_fetch_cache #(
   parameter int LINE_COUNT = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rom_chip_enable,
   input  logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] rom_data,
   output logic                  stall_from_if,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data
);

   localparam int IDX_W = $clog2(LINE_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [LINE_COUNT-1:0]   valid_q;
   logic [ADDR_WIDTH-1:0]   tag_q  [LINE_COUNT];
   logic [DATA_WIDTH-1:0]   data_q [LINE_COUNT];
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [IDX_W-1:0]        fetch_idx;
   logic [IDX_W-1:0]        fill_idx;
   logic                    line_hit;
   logic                    hit;
   logic                    miss;
   logic                    fill;

   // Lookup path. The whole address is kept as the tag, so a hit is a plain
   // equality compare. Outputs are forced quiet while reset is held so the
   // core never sees a stall or a stale instruction during reset.
   always_comb begin
      fetch_idx     = rom_addr[IDX_W+1:2];
      fill_idx      = req_addr[IDX_W+1:2];
      line_hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == rom_addr);
      hit           = !reset && rom_chip_enable && line_hit;
      miss          = !reset && rom_chip_enable && !line_hit;
      rom_data      = hit ? data_q[fetch_idx] : '0;
      stall_from_if = miss;
      mem_req_addr  = req_addr;
   end

   // Refill sequencer next-state logic. A started transaction always runs to
   // completion even if the core moves on, so REQ and WAIT ignore the fetch
   // inputs entirely; a response outside WAIT is ignored.
   always_comb begin
      next_state    = state;
      fill          = 1'b0;
      mem_req_valid = 1'b0;
      case (state)
         IDLE: begin
            if (miss) begin
               next_state = REQ;
            end
         end
         REQ: begin
            mem_req_valid = !reset;
            if (mem_req_ready) begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (mem_resp_valid) begin
               fill       = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State, request address and valid bits. Flush clears every valid bit and
   // takes priority over a fill landing on the same edge, so that fill ends
   // up invalid while the sequencer still returns to IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         req_addr <= '0;
         valid_q  <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && miss) begin
            req_addr <= rom_addr;
         end
         if (flush) begin
            valid_q <= '0;
         end else if (fill) begin
            valid_q[fill_idx] <= 1'b1;
         end
      end
   end

   // Tag and data storage. No reset is needed because every lookup is gated
   // by the valid bit; a fill overwrites whatever line lived at that index.
   always_ff @(posedge clock) begin
      if (!reset && fill) begin
         tag_q[fill_idx]  <= req_addr;
         data_q[fill_idx] <= mem_resp_data;
      end
   end

endmodule
